// File: rtl/muscle_trq_seq.sv
// muscle_trq_seq
//   Converts the flexor and extensor muscle forces (IEEE-754 single, N) into
//   joint torques (N*m) for the limb-dynamics stage. Each force is multiplied
//   by its moment arm on one shared float multiplier and clamped to
//   [0, TRQ_MAX]. Both torques are committed on the same edge.
//
//   Optional feature macro: TRQ_LPF_EN
//     When defined, each clamped torque passes through a first-order filter
//     t = prev + ALPHA*(t_clamped - prev) before commit. This adds FILT_F and
//     FILT_E states, so latency goes from 5 to 7 cycles.
//
//   Ports
//     clk        system clock
//     reset      asynchronous, active-high
//     start      single-cycle request for a new torque pair
//     f_flex     flexor force, float
//     f_ext      extensor force, float
//     trq1       flexor torque, float, >= 0
//     trq2       extensor torque, float, >= 0
//     busy       computation in progress
//     done       one-cycle pulse on the edge trq1/trq2 update
//     overrun    sticky: start seen while a computation was in flight
//     sat_count  saturating count of clamp-to-TRQ_MAX events
//
//   Handshake: start is sampled only in IDLE. busy rises on the accepting
//   edge and falls on the commit edge, where done pulses for one cycle with
//   the new trq1/trq2 pair. A start while busy (before commit) is dropped
//   and sets overrun; a start during the commit cycle is simply ignored.
module muscle_trq_seq #(
   parameter logic [31:0] ARM_FLEX = 32'h3CF5C28F,
   parameter logic [31:0] ARM_EXT  = 32'h3CF5C28F,
   parameter logic [31:0] TRQ_MAX  = 32'h41200000,
   parameter logic [31:0] ALPHA    = 32'h3F000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] f_flex,
   input  logic [31:0] f_ext,
   output logic [31:0] trq1,
   output logic [31:0] trq2,
   output logic        busy,
   output logic        done,
   output logic        overrun,
   output logic [15:0] sat_count
);

   typedef enum logic [2:0] {
      IDLE, MUL_F, CLAMP_F, MUL_E, CLAMP_E, COMMIT
`ifdef TRQ_LPF_EN
      , FILT_F, FILT_E
`endif
   } state_t;

   state_t      state;
   logic [31:0] f_flex_lat, f_ext_lat, prod, t1, t2;
   logic [31:0] mul_a, mul_b, mul_y;
   logic        sat_hit;

   // Float multiply, round-to-nearest-even. Denormals flush to zero.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic               s, g, st;
      logic signed [9:0]  e;
      logic [47:0]        p;
      logic [23:0]        m;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
         return 32'h7FC00000;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h7FC00000;
         return {s, 8'hFF, 23'h0};
      end
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) begin
         m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
      end else begin
         m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 24'd1;
      // Rounding 1.111..1 up carries into the next binade.
      if (m[23]) begin m = 24'h0; e = e + 10'sd1; end
      if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
      if (e <= 10'sd0)   return {s, 31'h0};
      return {s, e[7:0], m[22:0]};
   endfunction

   // One multiplier, operands selected by which channel is being processed.
   always_comb begin
      mul_a = f_ext_lat;
      mul_b = ARM_EXT;
      if (state == MUL_F) begin
         mul_a = f_flex_lat;
         mul_b = ARM_FLEX;
      end
      mul_y = fmul(mul_a, mul_b);
   end

   // Both operands are non-negative floats, so an unsigned integer compare
   // orders them correctly; +Inf compares above TRQ_MAX and clamps.
   assign sat_hit = (prod > TRQ_MAX);

`ifdef TRQ_LPF_EN
   logic [31:0] filt_t, filt_prev, filt_y;

   // Float add, round-to-nearest-even, denormals flush to zero.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       x, y;
      logic [7:0]        d;
      logic [26:0]       mx, my, mask;
      logic [27:0]       s;
      logic [23:0]       m;
      logic signed [9:0] e;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      if (x[30:23] == 8'hFF) return x;
      if (x[30:23] == 8'h00) return 32'h0;
      if (y[30:23] == 8'h00) return x;
      d    = x[30:23] - y[30:23];
      mx   = {1'b1, x[22:0], 3'b000};
      my   = {1'b1, y[22:0], 3'b000};
      mask = (27'd1 << d) - 27'd1;
      // Three extra bits (guard, round, sticky) keep the result within 1 ulp.
      if (d >= 8'd27) my = 27'd1;
      else            my = (my >> d) | {26'h0, |(my & mask)};
      e = $signed({2'b00, x[30:23]});
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin s = {1'b0, s[27:2], s[1] | s[0]}; e = e + 10'sd1; end
      end else begin
         s = {1'b0, mx} - {1'b0, my};
         if (s == '0) return 32'h0;
         for (int i = 0; i < 26; i++)
            if (!s[26]) begin s = s << 1; e = e - 10'sd1; end
      end
      m = {1'b0, s[25:3]};
      if (s[2] && (s[1] || s[0] || m[0])) m = m + 24'd1;
      if (m[23]) begin m = 24'h0; e = e + 10'sd1; end
      if (e >= 10'sd255) return {x[31], 8'hFF, 23'h0};
      if (e <= 10'sd0)   return 32'h0;
      return {x[31], e[7:0], m[22:0]};
   endfunction

   // Shared sub -> mult -> add chain, evaluated within one cycle.
   always_comb begin
      filt_t    = t2;
      filt_prev = trq2;
      if (state == FILT_F) begin
         filt_t    = t1;
         filt_prev = trq1;
      end
      filt_y = fadd(filt_prev,
                    fmul(ALPHA, fadd(filt_t, {~filt_prev[31], filt_prev[30:0]})));
   end
`else
   logic unused_alpha;
   assign unused_alpha = ^ALPHA;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         f_flex_lat <= '0;
         f_ext_lat  <= '0;
         prod       <= '0;
         t1         <= '0;
         t2         <= '0;
         trq1       <= '0;
         trq2       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         sat_count  <= '0;
      end else begin
         done <= 1'b0;
         if (start && state != IDLE && state != COMMIT) overrun <= 1'b1;
         case (state)
            IDLE: if (start) begin
               // Negative forces, including -0, are treated as no force.
               f_flex_lat <= f_flex[31] ? 32'h0 : f_flex;
               f_ext_lat  <= f_ext[31]  ? 32'h0 : f_ext;
               busy       <= 1'b1;
               state      <= MUL_F;
            end
            MUL_F: begin
               prod  <= mul_y;
               state <= CLAMP_F;
            end
            CLAMP_F: begin
               t1 <= sat_hit ? TRQ_MAX : prod;
               if (sat_hit && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`ifdef TRQ_LPF_EN
               state <= FILT_F;
`else
               state <= MUL_E;
`endif
            end
            MUL_E: begin
               prod  <= mul_y;
               state <= CLAMP_E;
            end
            CLAMP_E: begin
               t2 <= sat_hit ? TRQ_MAX : prod;
               if (sat_hit && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`ifdef TRQ_LPF_EN
               state <= FILT_E;
`else
               state <= COMMIT;
`endif
            end
`ifdef TRQ_LPF_EN
            FILT_F: begin
               t1    <= filt_y;
               state <= MUL_E;
            end
            FILT_E: begin
               t2    <= filt_y;
               state <= COMMIT;
            end
`endif
            COMMIT: begin
               trq1  <= t1;
               trq2  <= t2;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muscle_trq_seq.sv
// Testbench for muscle_trq_seq: directed vectors, a real-arithmetic reference
// model checked every cycle, and literal expectations for the listed cases.
module tb_muscle_trq_seq;

   localparam logic [31:0] ARM_FLEX = 32'h3CF5C28F;
   localparam logic [31:0] ARM_EXT  = 32'h3CF5C28F;
   localparam logic [31:0] TRQ_MAX  = 32'h41200000;
   localparam logic [31:0] ALPHA    = 32'h3F000000;
`ifdef TRQ_LPF_EN
   localparam int          LAT      = 7;
   localparam logic [31:0] NOM_T1   = 32'h3FC00000;  // 1.5 from trq1=0
`else
   localparam int          LAT      = 5;
   localparam logic [31:0] NOM_T1   = 32'h40400000;  // 3.0
`endif

   logic        clk, reset, start;
   logic [31:0] f_flex, f_ext, trq1, trq2;
   logic        busy, done, overrun;
   logic [15:0] sat_count;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   muscle_trq_seq #(
      .ARM_FLEX(ARM_FLEX), .ARM_EXT(ARM_EXT), .TRQ_MAX(TRQ_MAX), .ALPHA(ALPHA)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .f_flex(f_flex), .f_ext(f_ext),
      .trq1(trq1), .trq2(trq2), .busy(busy), .done(done), .overrun(overrun),
      .sat_count(sat_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (real arithmetic) ----------------
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'h00)      d = {f[31], 63'h0};
      else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'h0};
      else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
      return $bitstoreal(d);
   endfunction

   // Round a double to the nearest float (ties to even), flushing tiny values.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] m;
      int          e;
      d = $realtobits(r);
      if (d[62:52] == 11'h000) return {d[63], 31'h0};
      if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
      e = int'(d[62:52]) - 896;
      m = {2'b01, d[51:29]};
      if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) begin m = m >> 1; e++; end
      if (e >= 255) return {d[63], 8'hFF, 23'h0};
      if (e <= 0)   return {d[63], 31'h0};
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic void chan(input logic [31:0] f, input logic [31:0] arm,
                                output logic [31:0] t, output int clamped);
      real p;
      p = f[31] ? 0.0 : f2r(f) * f2r(arm);
      if (p > f2r(TRQ_MAX)) begin t = TRQ_MAX; clamped = 1; end
      else begin t = r2f(p); clamped = 0; end
   endfunction

   int          m_cnt, m_sat, pend_sat, c1, c2;
   logic [31:0] m_trq1, m_trq2, p1, p2;
   logic        m_busy, m_done, m_ovr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_sat = 0; pend_sat = 0;
         m_trq1 = '0; m_trq2 = '0; m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               chan(f_flex, ARM_FLEX, p1, c1);
               chan(f_ext, ARM_EXT, p2, c2);
               pend_sat = c1 + c2;
               m_busy   = 1'b1;
               m_cnt    = LAT;
            end
         end else begin
            if (start && m_cnt >= 2) m_ovr = 1'b1;
            if (m_cnt == 1) begin
`ifdef TRQ_LPF_EN
               p1 = r2f(f2r(m_trq1) + f2r(ALPHA) * (f2r(p1) - f2r(m_trq1)));
               p2 = r2f(f2r(m_trq2) + f2r(ALPHA) * (f2r(p2) - f2r(m_trq2)));
`endif
               m_trq1 = p1;
               m_trq2 = p2;
               m_done = 1'b1;
               m_busy = 1'b0;
               m_sat  = (m_sat + pend_sat > 65535) ? 65535 : m_sat + pend_sat;
            end
            m_cnt--;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("trq1", trq1, m_trq1);
         chk("trq2", trq2, m_trq2);
         chk("busy", {31'h0, busy}, {31'h0, m_busy});
         chk("done", {31'h0, done}, {31'h0, m_done});
         chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
         if (!m_busy) chk("sat_count", {16'h0, sat_count}, 32'(m_sat[15:0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic req(input logic [31:0] ff, input logic [31:0] fe);
      @(negedge clk);
      f_flex = ff;
      f_ext  = fe;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk({name, "_done_seen"}, {31'h0, got}, 32'h1);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   typedef struct packed {
      logic [31:0] ff, fe, t1, t2;
      logic [15:0] sat;
   } vec_t;

   vec_t vecs[$];
   int   n;

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1; start = 1'b0; f_flex = '0; f_ext = '0;
      repeat (2) @(negedge clk);
      chk("rst_trq1", trq1, 32'h0);
      chk("rst_trq2", trq2, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      chk("rst_sat", {16'h0, sat_count}, 32'h0);
      reset  = 1'b0;
      chk_en = 1'b1;

`ifdef TRQ_LPF_EN
      vecs.push_back({32'h42C80000, 32'h42480000, 32'h3FC00000, 32'h3F400000, 16'd0});
      vecs.push_back({32'h42C80000, 32'h42480000, 32'h40100000, 32'h3F900000, 16'd0});
`else
      vecs.push_back({32'h42C80000, 32'h42480000, 32'h40400000, 32'h3FC00000, 16'd0});
      vecs.push_back({32'h447A0000, 32'h42480000, 32'h41200000, 32'h3FC00000, 16'd1});
      vecs.push_back({32'h447A0000, 32'h447A0000, 32'h41200000, 32'h41200000, 16'd3});
      vecs.push_back({32'h42C80000, 32'hC0A00000, 32'h40400000, 32'h00000000, 16'd3});
      vecs.push_back({32'h80000000, 32'h42480000, 32'h00000000, 32'h3FC00000, 16'd3});
      vecs.push_back({32'h7F800000, 32'h3F800000, 32'h41200000, 32'h3CF5C28F, 16'd4});
      vecs.push_back({32'h00000000, 32'h43480000, 32'h00000000, 32'h40C00000, 16'd4});
`endif
      foreach (vecs[i]) begin
         req(vecs[i].ff, vecs[i].fe);
         wait_done($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_trq1", i), trq1, vecs[i].t1);
         chk($sformatf("vec%0d_trq2", i), trq2, vecs[i].t2);
         chk($sformatf("vec%0d_sat", i), {16'h0, sat_count}, {16'h0, vecs[i].sat});
         chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
      end

      // Second start two edges after the first: dropped, overrun set.
      req(32'h42C80000, 32'h42480000);
      @(negedge clk);
      f_flex = 32'h447A0000; f_ext = 32'h447A0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ovr");
`ifndef TRQ_LPF_EN
      chk("ovr_trq1", trq1, 32'h40400000);
      chk("ovr_trq2", trq2, 32'h3FC00000);
      chk("ovr_sat", {16'h0, sat_count}, 32'd4);
`endif
      chk("ovr_flag", {31'h0, overrun}, 32'h1);
      count_done(10, n);
      chk("ovr_no_second_done", n, 0);
      req(32'h3F800000, 32'h3F800000);
      wait_done("ovr_sticky");
      chk("ovr_sticky", {31'h0, overrun}, 32'h1);

      // Reset between edges N+2 and N+3 aborts the computation.
      req(32'h447A0000, 32'h447A0000);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_trq1", trq1, 32'h0);
      chk("mid_rst_trq2", trq2, 32'h0);
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_done", {31'h0, done}, 32'h0);
      chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
      chk("mid_rst_sat", {16'h0, sat_count}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      count_done(10, n);
      chk("mid_rst_no_done", n, 0);
      req(32'h42C80000, 32'h42480000);
      wait_done("post_rst");
      chk("post_rst_trq1", trq1, NOM_T1);
      chk("post_rst_sat", {16'h0, sat_count}, 32'h0);
      @(negedge clk);
      chk("post_rst_done_low", {31'h0, done}, 32'h0);

      // A few extra vectors checked by the model only.
      req(32'h41200000, 32'h43FA0000);
      wait_done("x0");
      req(32'h40490FDB, 32'h42F6E979);
      wait_done("x1");
      req(32'h4479FFFF, 32'h3A83126F);
      wait_done("x2");
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
